// File: rtl/led_matrix_scan_driver.sv
// Multiplexed LED matrix scan driver for daisy-chained 595-style shift registers.
// Optional feature macro: TEST_PATTERN_EN adds test_en, which replaces pixels with a checkerboard.
module led_matrix_scan_driver #(
  parameter int NUM_CHAINS = 36,
  parameter int CHAIN_LEN  = 8,
  parameter int NUM_COLS   = 8,
  parameter int PWM_BITS   = 8,
  parameter int CLK_DIV    = 32,
  parameter int ADDR_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
`ifdef TEST_PATTERN_EN
  input  logic                  test_en,
`endif
  output logic [ADDR_W-1:0]     fb_addr,
  input  logic [PWM_BITS-1:0]   fb_data,
  output logic [NUM_CHAINS-1:0] ser,
  output logic                  srclk,
  output logic                  rclk,
  output logic                  oe_n,
  output logic                  srclr_n,
  output logic [NUM_COLS-1:0]   col_sel,
  output logic                  frame_start
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] SETUP   = 3'd2;
  localparam logic [2:0] SHIFT   = 3'd3;
  localparam logic [2:0] LATCH   = 3'd4;
  localparam logic [2:0] DISPLAY = 3'd5;

  localparam int CNT_MAX = (NUM_CHAINS > CLK_DIV) ? NUM_CHAINS : CLK_DIV;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int COLW    = $clog2(NUM_COLS);

  logic [2:0]            state;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         b;
  logic [COLW-1:0]       col;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [NUM_CHAINS-1:0] stage, stage_nx;
  logic                  pix;
  logic                  last;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [COLW-1:0] c,
                                                input logic [BW-1:0] bb, input int ch);
    int a;
    a = int'(c) * CHAIN_LEN * NUM_CHAINS + int'(bb) * NUM_CHAINS + ch;
    return ADDR_W'(a);
  endfunction

  assign last = (cnt == CW'(CLK_DIV - 1));

  // In LOAD, cnt=k captures the pixel whose address went out at cnt=k-1.
  always_comb begin
    pix = (fb_data > pwm_cnt);
`ifdef TEST_PATTERN_EN
    if (test_en) pix = (((int'(cnt) - 1) + int'(b) + int'(col)) & 1) != 0;
`endif
    stage_nx = stage;
    for (int i = 0; i < NUM_CHAINS; i++)
      if (int'(cnt) == i + 1) stage_nx[i] = pix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      b           <= '0;
      col         <= '0;
      pwm_cnt     <= '0;
      stage       <= '0;
      fb_addr     <= '0;
      ser         <= '0;
      srclk       <= 1'b0;
      rclk        <= 1'b0;
      oe_n        <= 1'b1;
      srclr_n     <= 1'b0;
      col_sel     <= '0;
      frame_start <= 1'b0;
    end else begin
      srclr_n     <= 1'b1;
      frame_start <= 1'b0;
      cnt         <= cnt + 1'b1;
      case (state)
        IDLE: begin
          oe_n <= 1'b1;
          cnt  <= '0;
          if (enable) begin
            state       <= LOAD;
            b           <= BW'(CHAIN_LEN - 1);
            fb_addr     <= addr_of(col, BW'(CHAIN_LEN - 1), 0);
            frame_start <= (col == '0) && (pwm_cnt == '0);
          end
        end
        LOAD: begin
          stage <= stage_nx;
          if (int'(cnt) < NUM_CHAINS - 1) fb_addr <= addr_of(col, b, int'(cnt) + 1);
          if (int'(cnt) == NUM_CHAINS) begin
            ser   <= stage_nx;
            state <= SETUP;
            cnt   <= '0;
          end
        end
        SETUP: if (last) begin
          state <= SHIFT;
          srclk <= 1'b1;
          cnt   <= '0;
        end
        SHIFT: if (last) begin
          srclk <= 1'b0;
          cnt   <= '0;
          if (b == '0) begin
            // oe_n is already high here, so the column switch stays blanked
            state   <= LATCH;
            rclk    <= 1'b1;
            col_sel <= {{(NUM_COLS-1){1'b0}}, 1'b1} << col;
          end else begin
            state   <= LOAD;
            b       <= b - 1'b1;
            fb_addr <= addr_of(col, b - 1'b1, 0);
          end
        end
        LATCH: if (last) begin
          state <= DISPLAY;
          rclk  <= 1'b0;
          oe_n  <= 1'b0;
          cnt   <= '0;
        end
        DISPLAY: if (last) begin
          state   <= IDLE;
          oe_n    <= 1'b1;
          cnt     <= '0;
          pwm_cnt <= pwm_cnt + 1'b1;
          if (pwm_cnt == '1) begin
            if (int'(col) == NUM_COLS - 1) col <= '0;
            else                           col <= col + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Scoreboard bench for led_matrix_scan_driver: expected lines are queued at launch, popped at each latch.
module tb_led_matrix_scan_driver;
  localparam int NC = 2, CL = 4, NCOL = 2, PB = 2, CD = 2, AW = 16;
  localparam int LINE_PERIOD = CL * (NC + 1 + 2 * CD) + 2 * CD + 1;
  localparam int NPIX = NC * CL;

  logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic [AW-1:0]   fb_addr;
  logic [PB-1:0]   fb_data = '0;
  logic [NC-1:0]   ser;
  logic            srclk, rclk, oe_n, srclr_n, frame_start;
  logic [NCOL-1:0] col_sel;
`ifdef TEST_PATTERN_EN
  logic test_en = 1'b0;
`endif

  led_matrix_scan_driver #(.NUM_CHAINS(NC), .CHAIN_LEN(CL), .NUM_COLS(NCOL),
    .PWM_BITS(PB), .CLK_DIV(CD), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .enable(enable),
`ifdef TEST_PATTERN_EN
    .test_en(test_en),
`endif
    .fb_addr(fb_addr), .fb_data(fb_data), .ser(ser), .srclk(srclk), .rclk(rclk),
    .oe_n(oe_n), .srclr_n(srclr_n), .col_sel(col_sel), .frame_start(frame_start));

  always #5 clk = ~clk;

  // Framebuffer with one cycle of read latency
  logic [PB-1:0] mem [NPIX*NCOL];
  always @(posedge clk) fb_data <= (fb_addr < AW'(NPIX*NCOL)) ? mem[fb_addr[3:0]] : '0;

  typedef struct packed {
    logic [NPIX-1:0][AW-1:0] addrs;
    logic [CL-1:0][NC-1:0]   words;
    logic [NCOL-1:0]         sel;
    logic                    fs;
    logic                    contig;
  } line_t;

  line_t exp_q[$];
  int checks = 0, errors = 0;
  int line_idx = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line l of a scan: pwm level cycles fastest, column advances every 2^PB lines.
  function automatic line_t model(input int l, input bit contig);
    line_t e;
    int c, p, k, a;
    p = l % (1 << PB);
    c = (l / (1 << PB)) % NCOL;
    e = '0;
    e.sel = NCOL'(1 << c);
    e.fs = (p == 0 && c == 0);
    e.contig = contig;
    k = 0;
    for (int bb = CL - 1; bb >= 0; bb--)
      for (int ch = 0; ch < NC; ch++) begin
        a = c * CL * NC + bb * NC + ch;
        e.addrs[k] = AW'(a);
        k++;
        e.words[CL-1-bb][ch] = (int'(mem[a]) > p);
      end
    return e;
  endfunction

  // Monitor: collects one line of activity and scores it at the rclk rising edge
  int cyc = 0, latch_cnt = 0, sr_rise_cnt = 0, last_latch = 0;
  int n_addr = 0, n_word = 0, fs_cnt = 0, low_run = 0;
  logic [AW-1:0]   obs_addr [NPIX];
  logic [NC-1:0]   obs_word [CL];
  logic [AW-1:0]   p_addr = '0;
  logic [NC-1:0]   p_ser = '0;
  logic [NCOL-1:0] p_sel = '0;
  logic            p_srclk = 1'b0, p_rclk = 1'b0, p_oe_n = 1'b1;

  always @(negedge clk) begin
    line_t e;
    cyc++;
    if (rst) begin
      n_addr = 0; n_word = 0; fs_cnt = 0; low_run = 0;
      for (int k = 0; k < NPIX; k++) obs_addr[k] = '0;
      for (int k = 0; k < CL; k++) obs_word[k] = '0;
    end else begin
      chk("oe_n_low_with_rclk", (rclk && !oe_n) ? 1 : 0, 0);
      if (col_sel !== p_sel) chk("col_sel_change_unblanked", (oe_n && p_oe_n) ? 0 : 1, 0);
      if (ser !== p_ser) chk("ser_change_with_srclk", (srclk || p_srclk) ? 1 : 0, 0);
      if (fb_addr !== p_addr) begin
        if (n_addr < NPIX) obs_addr[n_addr] = fb_addr;
        n_addr++;
      end
      if (frame_start) fs_cnt++;
      if (srclk && !p_srclk) begin
        if (n_word < CL) obs_word[n_word] = ser;
        n_word++;
        sr_rise_cnt++;
      end
      if (!oe_n) low_run++;
      else if (!p_oe_n) begin
        chk("display_len", low_run, CD);
        low_run = 0;
      end
      if (rclk && !p_rclk) begin
        latch_cnt++;
        if (exp_q.size() == 0) chk("unexpected_latch", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("addr_count", n_addr, NPIX);
          for (int k = 0; k < NPIX; k++) chk($sformatf("addr%0d", k), obs_addr[k], e.addrs[k]);
          chk("shift_count", n_word, CL);
          for (int k = 0; k < CL; k++) chk($sformatf("ser_shift%0d", k), obs_word[k], e.words[k]);
          chk("col_sel", col_sel, e.sel);
          chk("frame_start", fs_cnt, e.fs);
          if (e.contig) chk("line_period", cyc - last_latch, LINE_PERIOD);
        end
        last_latch = cyc;
        n_addr = 0; n_word = 0; fs_cnt = 0;
        for (int k = 0; k < NPIX; k++) obs_addr[k] = '0;
        for (int k = 0; k < CL; k++) obs_word[k] = '0;
      end
    end
    p_addr = fb_addr; p_ser = ser; p_sel = col_sel;
    p_srclk = srclk; p_rclk = rclk; p_oe_n = oe_n;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Run n lines back to back, dropping enable mid-way through the last one.
  task automatic run_batch(input int n);
    int base_sr, base_l, t, snap_sr, oe_low;
    logic [AW-1:0] snap_addr;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model(line_idx, i > 0));
      line_idx++;
    end
    base_sr = sr_rise_cnt;
    base_l = latch_cnt;
    enable = 1'b1;
    t = 0;
    while (sr_rise_cnt < base_sr + CL * (n - 1) + 1 && t < 60 * n + 200) begin step(); t++; end
    chk("reach_last_line", (sr_rise_cnt >= base_sr + CL * (n - 1) + 1) ? 1 : 0, 1);
    t = 0;
    while (srclk && t < 50) begin step(); t++; end
    repeat (3) step();
    enable = 1'b0;
    t = 0;
    while (latch_cnt < base_l + n && t < 200) begin step(); t++; end
    chk("batch_latches", latch_cnt - base_l, n);
    repeat (10) step();
    snap_sr = sr_rise_cnt;
    snap_addr = fb_addr;
    oe_low = 0;
    repeat (20) begin step(); if (!oe_n) oe_low = 1; end
    chk("parked_srclk", sr_rise_cnt - snap_sr, 0);
    chk("parked_fb_addr", fb_addr, snap_addr);
    chk("parked_oe_n", oe_low, 0);
    chk("parked_col_sel", col_sel, model(line_idx - 1, 1'b0).sel);
  endtask

  initial begin
    int t, oe_low, rc_hi, base_sr;
    for (int i = 0; i < NPIX * NCOL; i++) mem[i] = '0;
    rst = 1'b1;
    enable = 1'b0;
    repeat (5) begin
      step();
      chk("reset_srclr_n", srclr_n, 0);
      chk("reset_oe_n", oe_n, 1);
    end
    chk("reset_col_sel", col_sel, 0);
    chk("reset_srclk", srclk, 0);
    chk("reset_rclk", rclk, 0);
    chk("reset_ser", ser, 0);
    chk("reset_fb_addr", fb_addr, 0);
    chk("reset_frame_start", frame_start, 0);

    rst = 1'b0;
    step();
    chk("release_srclr_n", srclr_n, 1);
    base_sr = sr_rise_cnt;
    oe_low = 0; rc_hi = 0;
    repeat (100) begin step(); if (!oe_n) oe_low = 1; if (rclk) rc_hi = 1; end
    chk("idle_srclk_edges", sr_rise_cnt - base_sr, 0);
    chk("idle_oe_n", oe_low, 0);
    chk("idle_rclk", rc_hi, 0);
    chk("idle_col_sel", col_sel, 0);

    // Full intensity: every pixel lit on the first line
    for (int i = 0; i < NPIX * NCOL; i++) mem[i] = 2'd3;
    run_batch(1);

    // One pixel at level 2, then cross into column 1
    for (int i = 0; i < NPIX * NCOL; i++) mem[i] = '0;
    mem[7] = 2'd2;
    run_batch(7);
    run_batch(1);

    repeat (6) begin
      for (int i = 0; i < NPIX * NCOL; i++) mem[i] = PB'($urandom);
      run_batch(int'($urandom_range(1, 5)));
    end

    // Abort in the middle of a shift pulse
    enable = 1'b1;
    t = 0;
    while (!srclk && t < 200) begin step(); t++; end
    chk("reach_shift", srclk, 1);
    rst = 1'b1;
    enable = 1'b0;
    step();
    chk("abort_srclk", srclk, 0);
    chk("abort_oe_n", oe_n, 1);
    chk("abort_col_sel", col_sel, 0);
    chk("abort_srclr_n", srclr_n, 0);
    chk("abort_ser", ser, 0);
    exp_q.delete();
    line_idx = 0;
    step();
    rst = 1'b0;
    step();
    chk("abort_release_srclr_n", srclr_n, 1);
    for (int i = 0; i < NPIX * NCOL; i++) mem[i] = PB'($urandom);
    run_batch(5);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
